// File: rtl/dphy_rx_pkg.sv
// Shared types and constants for the D-PHY receive lane.
// Contents: FSM state encoding, filtered LP line codes {p,n}, default sync byte.
package dphy_rx_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    STOP,
    HS_RQST,
    HS_PREP,
    SETTLE,
    SYNC_SEARCH,
    HS_RX,
    ERROR_WAIT
  } state_e;

  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_10 = 2'b10;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/dphy_rx_byte_aligner.sv
// Byte aligner for the HS stream.
// Keeps the previous deserialized byte so that a 16-bit window spanning two
// byte-clock cycles is available. While searching, finds the lowest bit offset
// at which SYNC_BYTE appears and latches it; afterwards outputs the window
// slice at that offset every cycle.
// Ports:
//   clk_phy, rst      byte clock, synchronous active-high reset
//   win_en            window capture enable (HS receiver on); window cleared when low
//   search_en         offset search active; latches offset on a hit
//   hs_byte           raw deserialized byte, bit0 earliest
//   sync_found        hit while search_en is high
//   aligned_byte      window slice at the latched offset
module dphy_rx_byte_aligner
  import dphy_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic       clk_phy,
  input  logic       rst,
  input  logic       win_en,
  input  logic       search_en,
  input  logic [7:0] hs_byte,
  output logic       sync_found,
  output logic [7:0] aligned_byte
);

  logic [7:0]  prev_byte_q, prev_byte_d;
  logic [2:0]  offset_q, offset_d;
  logic [15:0] window;
  logic        hit;
  logic [2:0]  hit_k;

  // Older byte in the low half: window bit order matches arrival order.
  assign window = {hs_byte, prev_byte_q};

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = 7; k >= 0; k--) begin
      if (window[k +: 8] == SYNC_BYTE) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  always_comb begin
    prev_byte_d = win_en ? hs_byte : '0;
    offset_d    = (search_en && hit) ? hit_k : offset_q;
  end

  always_ff @(posedge clk_phy) begin
    if (rst) begin
      prev_byte_q <= '0;
      offset_q    <= '0;
    end else begin
      prev_byte_q <= prev_byte_d;
      offset_q    <= offset_d;
    end
  end

  assign sync_found   = search_en & hit;
  assign aligned_byte = window[offset_q +: 8];

endmodule

// File: rtl/dphy_rx_lane_controller.sv
// One D-PHY data lane receiver.
// Conditions the asynchronous LP pair (2-flop sync + 2-sample filter), runs the
// lane FSM (Stop -> HS request -> settle -> sync search -> HS receive) and emits
// aligned payload bytes with start/end-of-transmission and sync-error pulses.
// All outputs are registered.
// Ports:
//   clk_phy, rst          byte clock, synchronous active-high reset
//   lane_enable           0 forces DISABLED with idle outputs
//   LP_p_input/LP_n_input asynchronous LP lines
//   hs_lane_input         unaligned deserialized HS byte
//   hs_settle_timeout     settle wait in clk_phy cycles
//   hs_term_enable        HS termination / receiver enable
//   rx_data/rx_valid      aligned payload byte stream
//   rx_sot/rx_eot         burst start / end pulses
//   rx_sync_error         sync timeout or illegal LP sequence pulse
//   lane_stop_state       lane in STOP
//   lane_active           lane in HS_RQST..HS_RX
module dphy_rx_lane_controller
  import dphy_rx_pkg::*;
#(
  parameter int         SYNC_SEARCH_TIMEOUT = 32,
  parameter logic [7:0] SYNC_BYTE           = DEFAULT_SYNC_BYTE
) (
  input  logic       clk_phy,
  input  logic       rst,
  input  logic       lane_enable,
  input  logic       LP_p_input,
  input  logic       LP_n_input,
  input  logic [7:0] hs_lane_input,
  input  logic [7:0] hs_settle_timeout,
  output logic       hs_term_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sot,
  output logic       rx_eot,
  output logic       rx_sync_error,
  output logic       lane_stop_state,
  output logic       lane_active
);

  localparam int SCW = $clog2(SYNC_SEARCH_TIMEOUT + 1);

  // LP conditioning
  logic [1:0] lp_s1_q, lp_s1_d, lp_s2_q, lp_s2_d, lp_prev_q, lp_prev_d, lp_filt_q, lp_filt_d;

  always_comb begin
    lp_s1_d   = {LP_p_input, LP_n_input};
    lp_s2_d   = lp_s1_q;
    lp_prev_d = lp_s2_q;
    lp_filt_d = (lp_s2_q == lp_prev_q) ? lp_s2_q : lp_filt_q;
  end

  // FSM state, counters and registered outputs
  state_e     state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [SCW-1:0] search_cnt_q, search_cnt_d;
  logic       sot_pend_q, sot_pend_d;
  logic       term_q, term_d, valid_q, valid_d, sot_q, sot_d, eot_q, eot_d;
  logic       err_q, err_d, stop_q, stop_d, active_q, active_d;
  logic [7:0] data_q, data_d;

  logic       sync_found;
  logic [7:0] aligned_byte;

  dphy_rx_byte_aligner #(.SYNC_BYTE(SYNC_BYTE)) u_aligner (
    .clk_phy      (clk_phy),
    .rst          (rst),
    .win_en       (term_q),
    .search_en    (state_q == SYNC_SEARCH),
    .hs_byte      (hs_lane_input),
    .sync_found   (sync_found),
    .aligned_byte (aligned_byte)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    search_cnt_d = search_cnt_q;
    sot_pend_d   = sot_pend_q;
    valid_d      = 1'b0;
    data_d       = '0;
    sot_d        = 1'b0;
    eot_d        = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      DISABLED:    if (lane_enable && lp_filt_q == LP_11) state_d = STOP;
      STOP: begin
        if (lp_filt_q == LP_01) state_d = HS_RQST;
        else if (lp_filt_q != LP_11) state_d = ERROR_WAIT;
      end
      HS_RQST: begin
        if (lp_filt_q == LP_00) state_d = HS_PREP;
        else if (lp_filt_q == LP_11) state_d = STOP;
        else if (lp_filt_q == LP_10) begin
          state_d = ERROR_WAIT;
          err_d   = 1'b1;
        end
      end
      HS_PREP: begin
        settle_cnt_d = hs_settle_timeout;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (lp_filt_q == LP_11) state_d = STOP;
        else if (settle_cnt_q == '0) begin
          state_d      = SYNC_SEARCH;
          search_cnt_d = '0;
        end else settle_cnt_d = settle_cnt_q - 8'd1;
      end
      SYNC_SEARCH: begin
        if (lp_filt_q == LP_11) state_d = STOP;
        else if (sync_found) begin
          state_d    = HS_RX;
          sot_pend_d = 1'b1;
        end else if (search_cnt_q == SCW'(SYNC_SEARCH_TIMEOUT - 1)) begin
          state_d = ERROR_WAIT;
          err_d   = 1'b1;
        end else search_cnt_d = search_cnt_q + 1'b1;
      end
      HS_RX: begin
        if (lp_filt_q == LP_11) begin
          state_d = STOP;
          eot_d   = 1'b1;
        end else begin
          valid_d    = 1'b1;
          data_d     = aligned_byte;
          sot_d      = sot_pend_q;
          sot_pend_d = 1'b0;
        end
      end
      ERROR_WAIT:  if (lp_filt_q == LP_11) state_d = STOP;
      default:     state_d = DISABLED;
    endcase
    // Disable overrides everything and is silent.
    if (!lane_enable) begin
      state_d    = DISABLED;
      valid_d    = 1'b0;
      data_d     = '0;
      sot_d      = 1'b0;
      eot_d      = 1'b0;
      err_d      = 1'b0;
      sot_pend_d = 1'b0;
    end
    term_d   = state_d inside {HS_PREP, SETTLE, SYNC_SEARCH, HS_RX};
    stop_d   = (state_d == STOP);
    active_d = state_d inside {HS_RQST, HS_PREP, SETTLE, SYNC_SEARCH, HS_RX};
  end

  always_ff @(posedge clk_phy) begin
    if (rst) begin
      lp_s1_q      <= '0;
      lp_s2_q      <= '0;
      lp_prev_q    <= '0;
      lp_filt_q    <= '0;
      state_q      <= DISABLED;
      settle_cnt_q <= '0;
      search_cnt_q <= '0;
      sot_pend_q   <= 1'b0;
      term_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      sot_q        <= 1'b0;
      eot_q        <= 1'b0;
      err_q        <= 1'b0;
      stop_q       <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      lp_s1_q      <= lp_s1_d;
      lp_s2_q      <= lp_s2_d;
      lp_prev_q    <= lp_prev_d;
      lp_filt_q    <= lp_filt_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      search_cnt_q <= search_cnt_d;
      sot_pend_q   <= sot_pend_d;
      term_q       <= term_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      sot_q        <= sot_d;
      eot_q        <= eot_d;
      err_q        <= err_d;
      stop_q       <= stop_d;
      active_q     <= active_d;
    end
  end

  assign hs_term_enable  = term_q;
  assign rx_data         = data_q;
  assign rx_valid        = valid_q;
  assign rx_sot          = sot_q;
  assign rx_eot          = eot_q;
  assign rx_sync_error   = err_q;
  assign lane_stop_state = stop_q;
  assign lane_active     = active_q;

endmodule

// File: tb/tb_dphy_rx_lane_controller.sv
// Directed bench for dphy_rx_lane_controller: LP request detection, settle,
// aligned and bit-shifted sync, sync timeout, LP aborts, disable and reset.
module tb_dphy_rx_lane_controller;

  logic       clk_phy = 1'b0;
  logic       rst = 1'b1;
  logic       lane_enable = 1'b0;
  logic       LP_p_input = 1'b1;
  logic       LP_n_input = 1'b1;
  logic [7:0] hs_lane_input = 8'h00;
  logic [7:0] hs_settle_timeout = 8'd4;
  logic       hs_term_enable, rx_valid, rx_sot, rx_eot, rx_sync_error;
  logic       lane_stop_state, lane_active;
  logic [7:0] rx_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Stream with sync byte at byte index 2, payload 11 22 33, then zeros.
  logic [63:0] v_stream = {8'h00, 8'h00, 8'h33, 8'h22, 8'h11, 8'hB8, 8'h00, 8'h00};
  logic [7:0]  exp_pay [3] = '{8'h11, 8'h22, 8'h33};

  always #5 clk_phy = ~clk_phy;

  dphy_rx_lane_controller dut (
    .clk_phy           (clk_phy),
    .rst               (rst),
    .lane_enable       (lane_enable),
    .LP_p_input        (LP_p_input),
    .LP_n_input        (LP_n_input),
    .hs_lane_input     (hs_lane_input),
    .hs_settle_timeout (hs_settle_timeout),
    .hs_term_enable    (hs_term_enable),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_sot            (rx_sot),
    .rx_eot            (rx_eot),
    .rx_sync_error     (rx_sync_error),
    .lane_stop_state   (lane_stop_state),
    .lane_active       (lane_active)
  );

  task automatic step();
    @(posedge clk_phy);
    #1;
  endtask

  task automatic set_lp(input logic [1:0] c);
    LP_p_input = c[1];
    LP_n_input = c[0];
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; lane_enable = 1'b1; set_lp(2'b11);
    repeat (3) step();
    total_cnt++; if ({hs_term_enable, rx_data, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_stop_state, lane_active} !== 15'd0)
      $display("FAIL reset_outputs got %h exp 0", {hs_term_enable, rx_data, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_stop_state, lane_active}); else pass_cnt++;
    rst = 1'b0;
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL reset_stop_latency got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if ({hs_term_enable, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_active} !== 6'd0)
      $display("FAIL stop_outputs got %b exp 000000", {hs_term_enable, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_active}); else pass_cnt++;
  endtask

  // From STOP: LP-01 then LP-00, returns on the cycle HS_PREP is observed.
  task automatic hs_enter();
    int n;
    set_lp(2'b01);
    n = 0;
    while (lane_active !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL rqst_latency got %0d exp 5", n); else pass_cnt++;
    set_lp(2'b00);
    n = 0;
    while (hs_term_enable !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL prep_latency got %0d exp 5", n); else pass_cnt++;
  endtask

  task automatic burst(input logic [63:0] s, input int first, input int nb);
    hs_enter();
    hs_lane_input = 8'h00;
    repeat (8) step();
    for (int i = 0; i < nb; i++) begin
      hs_lane_input = s[8*(first+i) +: 8];
      step();
      if (i < 2) begin
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL pre_valid%0d got %b exp 0", i, rx_valid); else pass_cnt++;
      end else begin
        total_cnt++; if (rx_valid !== 1'b1 || rx_data !== exp_pay[i-2])
          $display("FAIL payload%0d got v=%b d=%h exp v=1 d=%h", i-2, rx_valid, rx_data, exp_pay[i-2]); else pass_cnt++;
        total_cnt++; if (rx_sot !== (i == 2)) $display("FAIL sot%0d got %b exp %b", i-2, rx_sot, (i == 2)); else pass_cnt++;
      end
      total_cnt++; if (rx_sync_error !== 1'b0) $display("FAIL burst_err%0d got %b exp 0", i, rx_sync_error); else pass_cnt++;
    end
    hs_lane_input = 8'h00;
  endtask

  task automatic end_burst();
    int n;
    set_lp(2'b11);
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL eot_latency got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if ({rx_eot, rx_valid, rx_sot, rx_sync_error, lane_active, hs_term_enable} !== 6'b100000)
      $display("FAIL eot_cycle got %b exp 100000", {rx_eot, rx_valid, rx_sot, rx_sync_error, lane_active, hs_term_enable}); else pass_cnt++;
    step();
    total_cnt++; if (rx_eot !== 1'b0) $display("FAIL eot_pulse_width got %b exp 0", rx_eot); else pass_cnt++;
  endtask

  task automatic test_aligned();
    burst(v_stream, 2, 5);
    end_burst();
  endtask

  task automatic test_shifted();
    burst(v_stream << 3, 2, 5);
    end_burst();
  endtask

  task automatic test_sync_timeout();
    int n_err, err_at, n;
    hs_enter();
    hs_lane_input = 8'h00;
    n_err = 0; err_at = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (rx_sync_error === 1'b1) begin n_err++; if (err_at < 0) err_at = i; end
    end
    total_cnt++; if (n_err !== 1) $display("FAIL timeout_err_count got %0d exp 1", n_err); else pass_cnt++;
    total_cnt++; if (err_at !== 38) $display("FAIL timeout_err_cycle got %0d exp 38", err_at); else pass_cnt++;
    total_cnt++; if ({hs_term_enable, lane_active, lane_stop_state} !== 3'b000)
      $display("FAIL error_wait_outputs got %b exp 000", {hs_term_enable, lane_active, lane_stop_state}); else pass_cnt++;
    set_lp(2'b11);
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL timeout_recover got %0d exp 5", n); else pass_cnt++;
  endtask

  task automatic test_lp_abort();
    int n, errs;
    set_lp(2'b01);
    n = 0;
    while (lane_active !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL abort_rqst got %0d exp 5", n); else pass_cnt++;
    set_lp(2'b11);
    n = 0; errs = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; if (rx_sync_error === 1'b1) errs++; end
    total_cnt++; if (n !== 5) $display("FAIL abort_stop got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (errs !== 0) $display("FAIL abort_err got %0d exp 0", errs); else pass_cnt++;
    set_lp(2'b10);
    n = 0; errs = 0;
    while (lane_stop_state === 1'b1 && n < 20) begin step(); n++; if (rx_sync_error === 1'b1) errs++; end
    total_cnt++; if (n !== 5) $display("FAIL lp10_leave_stop got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if ({errs != 0, hs_term_enable, lane_active} !== 3'b000)
      $display("FAIL lp10_outputs got %b exp 000", {errs != 0, hs_term_enable, lane_active}); else pass_cnt++;
    set_lp(2'b11);
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL lp10_recover got %0d exp 5", n); else pass_cnt++;
  endtask

  task automatic test_disable_mid();
    int n;
    burst(v_stream, 2, 3);
    lane_enable = 1'b0;
    step();
    total_cnt++; if ({rx_valid, rx_eot, rx_sync_error, rx_sot, lane_stop_state, lane_active, hs_term_enable} !== 7'd0)
      $display("FAIL disable_outputs got %b exp 0000000", {rx_valid, rx_eot, rx_sync_error, rx_sot, lane_stop_state, lane_active, hs_term_enable}); else pass_cnt++;
    set_lp(2'b11);
    lane_enable = 1'b1;
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n >= 20) $display("FAIL disable_recover got timeout exp stop"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    burst(v_stream << 3, 2, 3);
    rst = 1'b1;
    step();
    total_cnt++; if ({hs_term_enable, rx_data, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_stop_state, lane_active} !== 15'd0)
      $display("FAIL midreset_outputs got %h exp 0", {hs_term_enable, rx_data, rx_valid, rx_sot, rx_eot, rx_sync_error, lane_stop_state, lane_active}); else pass_cnt++;
    step();
    rst = 1'b0;
    set_lp(2'b11);
    n = 0;
    while (lane_stop_state !== 1'b1 && n < 20) begin step(); n++; end
    total_cnt++; if (n !== 5) $display("FAIL midreset_recover got %0d exp 5", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_shifted();
    test_sync_timeout();
    test_lp_abort();
    test_disable_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

endmodule
